// File: rtl/mcpu_pkg.sv
// Shared constants and loader state encoding for the MCPU boot loader.
package mcpu_pkg;

    localparam int unsigned WORD_SIZE  = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned RAM_SIZE   = 2 ** ADDR_WIDTH;
    // Word count range is 1..256, so one bit wider than a byte.
    localparam int unsigned CNT_W      = 9;

    typedef enum logic [2:0] {
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_CLEAR,
        ST_RUN,
        ST_ERROR
    } loader_state_e;

endpackage

// File: rtl/mcpu_loader_cksum.sv
// Running XOR of accepted stream bytes, with compare against a candidate checksum byte.
module mcpu_loader_cksum
    import mcpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] din,
    output logic              match_c
);

    logic [BYTE_W-1:0] acc_q;
    logic [BYTE_W-1:0] acc_d;

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign match_c = (acc_q == din);

endmodule

// File: rtl/mcpu_program_loader.sv
// Boot loader: receives count/words/checksum bytes, writes instruction RAM,
// zero-fills the tail and releases the MCPU core once the image is verified.
module mcpu_program_loader
    import mcpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int unsigned HI_W = WORD_SIZE - BYTE_W;

    loader_state_e         state_q, state_d;
    logic [HI_W-1:0]       hi_q, hi_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    logic                  accept_c;
    logic                  ck_en_c;
    logic                  ck_clr_c;
    logic                  ck_match_c;
    logic [CNT_W-1:0]      count_byte_c;

    assign accept_c     = in_valid & in_ready_q;
    // A count byte of zero stands for a full 256-word image.
    assign count_byte_c = (in_data == '0) ? CNT_W'(256) : CNT_W'(in_data);

    mcpu_loader_cksum u_cksum (
        .clk     (clk),
        .reset   (reset),
        .clr     (ck_clr_c),
        .en      (ck_en_c),
        .din     (in_data),
        .match_c (ck_match_c)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ck_en_c     = 1'b0;
        ck_clr_c    = 1'b0;

        case (state_q)
            ST_COUNT: begin
                if (accept_c) begin
                    ck_en_c = 1'b1;
                    cnt_d   = count_byte_c;
                    state_d = (count_byte_c > CNT_W'(RAM_SIZE)) ? ST_ERROR : ST_HI;
                end
            end
            ST_HI: begin
                if (accept_c) begin
                    ck_en_c = 1'b1;
                    hi_d    = in_data;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (accept_c) begin
                    ck_en_c     = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wcnt_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = {hi_q, in_data};
                    wcnt_d      = wcnt_q + CNT_W'(1);
                    state_d     = ((wcnt_q + CNT_W'(1)) == cnt_q) ? ST_CSUM : ST_HI;
                end
            end
            ST_CSUM: begin
                if (accept_c) begin
                    if (!ck_match_c) begin
                        state_d = ST_ERROR;
                    end else if (cnt_q == CNT_W'(RAM_SIZE)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                // wcnt_q already equals N here, so it doubles as the clear address.
                mem_we_d    = 1'b1;
                mem_addr_d  = wcnt_q[ADDR_WIDTH-1:0];
                mem_wdata_d = '0;
                wcnt_d      = wcnt_q + CNT_W'(1);
                if (wcnt_q == CNT_W'(RAM_SIZE - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (reload) begin
                    ck_clr_c = 1'b1;
                    cnt_d    = '0;
                    wcnt_d   = '0;
                    state_d  = ST_COUNT;
                end
            end
            default: begin
                state_d = ST_COUNT;
            end
        endcase

        // Status outputs follow the state being entered so they register in step with it.
        in_ready_d   = (state_d == ST_COUNT) || (state_d == ST_HI) ||
                       (state_d == ST_LO)    || (state_d == ST_CSUM);
        cpu_reset_d  = (state_d != ST_RUN);
        load_done_d  = (state_d == ST_RUN);
        load_error_d = (state_d == ST_ERROR);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_COUNT;
            hi_q         <= '0;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            in_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_mcpu_program_loader.sv
// Scoreboard bench for mcpu_program_loader: expected RAM writes are queued by
// the stimulus, and a monitor pops and compares on every mem_we pulse.
module tb_mcpu_program_loader;
    import mcpu_pkg::*;

    logic                  clk;
    logic                  reset;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  reload;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_SIZE-1:0]  mem_wdata;
    logic                  cpu_reset;
    logic                  load_done;
    logic                  load_error;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] stream[$];
    int         n_checks;
    int         n_fail;
    int         we_count;
    int         we_base;
    bit         ended;

    mcpu_program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reload     (reload),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we === 1'b1) begin
            we_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
            end
        end
    end

    // Present one byte, wait (bounded) for the transfer, then optionally idle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge clk);
        if (in_ready !== 1'b1) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_stream(input int gap);
        foreach (stream[i]) send_byte(stream[i], gap);
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        ended = 1'b0;
        for (int i = 0; i < budget && !ended; i++) begin
            if (load_done === 1'b1 || load_error === 1'b1) ended = 1'b1;
            else @(negedge clk);
        end
        check(name, 32'(ended), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd1);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
        check({tag, "_load_done"},  32'(load_done),  32'd0);
        check({tag, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    // Image of test 1: two words then zero fill.
    task automatic push_test1();
        exp_q.push_back('{addr: 8'h00, data: 16'h1234});
        exp_q.push_back('{addr: 8'h01, data: 16'hABCD});
        for (int a = 2; a < 256; a++) exp_q.push_back('{addr: 8'(a), data: 16'h0000});
        stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    endtask

    task automatic check_run(input string tag);
        check({tag, "_we_count"},   32'(we_count - we_base), 32'd256);
        check({tag, "_q_empty"},    32'(exp_q.size()),       32'd0);
        check({tag, "_load_done"},  32'(load_done),          32'd1);
        check({tag, "_cpu_reset"},  32'(cpu_reset),          32'd0);
        check({tag, "_load_error"}, 32'(load_error),         32'd0);
        check({tag, "_in_ready"},   32'(in_ready),           32'd0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        logic [7:0] cs;
        n_checks = 0;
        n_fail   = 0;
        we_count = 0;
        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);

        // Test 1: back-to-back bytes, good checksum.
        push_test1();
        we_base = we_count;
        send_stream(0);
        wait_end("t1_end", 400);
        check_run("t1");

        // Reload from RUN: core back in reset on the next cycle.
        pulse_reload();
        check("t6_run_reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t6_run_reload_done",      32'(load_done), 32'd0);
        check("t6_run_reload_in_ready",  32'(in_ready),  32'd1);

        // Test 2: bad checksum ends in ERROR after two writes.
        exp_q.push_back('{addr: 8'h00, data: 16'h1234});
        exp_q.push_back('{addr: 8'h01, data: 16'hABCD});
        stream  = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        we_base = we_count;
        send_stream(0);
        wait_end("t2_end", 50);
        repeat (5) @(negedge clk);
        check("t2_load_error", 32'(load_error),          32'd1);
        check("t2_cpu_reset",  32'(cpu_reset),           32'd1);
        check("t2_in_ready",   32'(in_ready),            32'd0);
        check("t2_load_done",  32'(load_done),           32'd0);
        check("t2_we_count",   32'(we_count - we_base),  32'd2);

        // Reload from ERROR, then test 3: gapped stream.
        pulse_reload();
        check("t6_err_reload_error",    32'(load_error), 32'd0);
        check("t6_err_reload_in_ready", 32'(in_ready),   32'd1);
        push_test1();
        we_base = we_count;
        send_stream(3);
        wait_end("t3_end", 400);
        check_run("t3");

        // Test 4: async reset right after the first word is written.
        pulse_reload();
        exp_q.push_back('{addr: 8'h00, data: 16'h1234});
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        in_valid = 1'b0;
        #1;
        check("t4_first_word", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        #2;
        check_reset_vals("t4_rst");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_test1();
        we_base = we_count;
        send_stream(0);
        wait_end("t4_end", 400);
        check_run("t4");

        // Test 5: count 00 means 256 words, no zero fill.
        pulse_reload();
        stream.delete();
        stream.push_back(8'h00);
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            stream.push_back(8'(i));
            stream.push_back(~8'(i));
            cs = cs ^ 8'(i) ^ ~8'(i);
            exp_q.push_back('{addr: 8'(i), data: {8'(i), ~8'(i)}});
        end
        stream.push_back(cs);
        we_base = we_count;
        send_stream(0);
        wait_end("t5_end", 700);
        check_run("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
